// File: rtl/out_port_buffer_pkg.sv
// Shared widths and sizing for the processor port buffers.
// Constants only; no logic, no latency, no flow control.
package out_port_buffer_pkg;

    localparam int IN_PORT_WIDTH  = 16;
    localparam int OUT_PORT_WIDTH = 16;
    localparam int OUT_BUF_DEPTH  = 8;

    // Occupancy counters need one extra bit so that DEPTH itself is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_port_buffer_if.sv
// Processor-side strobe plus peripheral-side valid/ready bundle for the output port buffer.
// Wires only; the slave modport belongs to the buffer, the master modport to its environment.
interface out_port_buffer_if
    import out_port_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = OUT_PORT_WIDTH,
    parameter int DEPTH      = OUT_BUF_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic                  outSignalEn;
    logic [DATA_WIDTH-1:0] outPortData;
    logic                  portReady;
    logic                  overflowClr;
    logic                  portValid;
    logic [DATA_WIDTH-1:0] portData;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  overflow;

    modport slave (
        input  outSignalEn, outPortData, portReady, overflowClr,
        output portValid, portData, count, full, overflow
    );

    modport master (
        output outSignalEn, outPortData, portReady, overflowClr,
        input  portValid, portData, count, full, overflow
    );

endinterface

// File: rtl/out_port_buffer_fifo_regarray.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous (combinational) read.
// No flow control; the owner decides when writes happen and which entry is read.
module fifo_regarray #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/out_port_buffer.sv
// Buffers OUT-instruction strobes in a small FIFO and offers them to a peripheral via valid/ready.
// One cycle strobe-to-valid; never stalls the writer, drops when full and flags sticky overflow.
module out_port_buffer
    import out_port_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = OUT_PORT_WIDTH,
    parameter int DEPTH      = OUT_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    out_port_buffer_if.slave bus
);

    // DEPTH must be a power of two (>= 2) so pointers wrap by plain overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_head;

    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        w_pop   = w_valid && bus.portReady;
        // A pop in the same cycle frees the slot, so a full buffer still accepts the write.
        w_push  = bus.outSignalEn && (!w_full || w_pop);
        w_drop  = bus.outSignalEn && w_full && !w_pop;
    end

    fifo_regarray #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push && !reset),
        .waddr (r_wr_ptr),
        .wdata (bus.outPortData),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.overflowClr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.portValid = w_valid;
    assign bus.portData  = w_valid ? w_head : '0;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_out_port_buffer;
    import out_port_buffer_pkg::*;

    localparam int DW    = OUT_PORT_WIDTH;
    localparam int DEPTH = OUT_BUF_DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    out_port_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    out_port_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue of accepted entries plus the sticky flag.
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    int            m_drops;
    int            m_strobes;
    int            dut_pops;

    typedef struct {
        logic          rst;
        logic          en;
        logic [DW-1:0] din;
        logic          rdy;
        logic          clr;
        logic          x_valid;
        logic [DW-1:0] x_data;
        int            x_count;
        logic          x_full;
        logic          x_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [DW-1:0] d,
                         input logic rdy, input logic clr);
        reset           = rst;
        bus.outSignalEn = en;
        bus.outPortData = d;
        bus.portReady   = rdy;
        bus.overflowClr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance model by one clock using the currently driven inputs, then clock the DUT.
    task automatic mstep();
        bit pop_m;
        bit full_m;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (bus.portValid === 1'b1 && bus.portReady) dut_pops++;
            pop_m  = (mq.size() > 0) && bus.portReady;
            full_m = (mq.size() == DEPTH);
            if (bus.outSignalEn) m_strobes++;
            if (pop_m) void'(mq.pop_front());
            if (bus.overflowClr) m_ovf = 1'b0;
            if (bus.outSignalEn && full_m && !pop_m) begin
                m_drops++;
                m_ovf = 1'b1;
            end else if (bus.outSignalEn) begin
                mq.push_back(bus.outPortData);
            end
        end
        step();
    endtask

    task automatic check_model(input int cyc);
        logic [DW-1:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : '0;
        chk($sformatf("rnd[%0d].valid", cyc), 32'(bus.portValid), 32'(mq.size() > 0));
        chk($sformatf("rnd[%0d].data", cyc), 32'(bus.portData), 32'(exp_d));
        chk($sformatf("rnd[%0d].count", cyc), 32'(bus.count), 32'(mq.size()));
        chk($sformatf("rnd[%0d].full", cyc), 32'(bus.full), 32'(mq.size() == DEPTH));
        chk($sformatf("rnd[%0d].ovf", cyc), 32'(bus.overflow), 32'(m_ovf));
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

        //        rst   en    din       rdy   clr   valid data      cnt full  ovf
        vecs[0]  = '{1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
        // Empty + write + ready: no bypass, so the entry is still there afterwards.
        vecs[9]  = '{1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h5555, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};

        step();
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            step();
            chk($sformatf("vec[%0d].valid", i), 32'(bus.portValid), 32'(vecs[i].x_valid));
            chk($sformatf("vec[%0d].data", i), 32'(bus.portData), 32'(vecs[i].x_data));
            chk($sformatf("vec[%0d].count", i), 32'(bus.count), 32'(vecs[i].x_count));
            chk($sformatf("vec[%0d].full", i), 32'(bus.full), 32'(vecs[i].x_full));
            chk($sformatf("vec[%0d].ovf", i), 32'(bus.overflow), 32'(vecs[i].x_ovf));
        end

        // Fill with 1..8, then drain continuously and confirm order.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
            step();
        end
        chk("fill1.count", 32'(bus.count), 32'd8);
        chk("fill1.full", 32'(bus.full), 32'd1);
        chk("fill1.head", 32'(bus.portData), 32'h0001);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            chk($sformatf("drain1[%0d].valid", k), 32'(bus.portValid), 32'd1);
            chk($sformatf("drain1[%0d].data", k), 32'(bus.portData), 32'(k));
            step();
        end
        chk("drain1.empty_valid", 32'(bus.portValid), 32'd0);
        chk("drain1.empty_data", 32'(bus.portData), 32'd0);
        chk("drain1.empty_count", 32'(bus.count), 32'd0);

        // Refill across the wrapped pointers, then exercise overflow handling.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
            step();
        end
        chk("fill2.full", 32'(bus.full), 32'd1);
        drive(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        step();
        chk("ovf.set", 32'(bus.overflow), 32'd1);
        chk("ovf.count", 32'(bus.count), 32'd8);
        chk("ovf.head", 32'(bus.portData), 32'h0001);
        drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        step();
        chk("ovf.clr_vs_drop", 32'(bus.overflow), 32'd1);
        chk("ovf.clr_vs_drop_count", 32'(bus.count), 32'd8);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step();
        chk("ovf.clr", 32'(bus.overflow), 32'd0);

        // Full with simultaneous pop and push: 9 must be accepted and come out last.
        drive(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0);
        step();
        chk("pp.count", 32'(bus.count), 32'd8);
        chk("pp.ovf", 32'(bus.overflow), 32'd0);
        chk("pp.head", 32'(bus.portData), 32'h0002);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("drain2[%0d].data", k), 32'(bus.portData), 32'(k));
            step();
        end
        chk("drain2.empty_valid", 32'(bus.portValid), 32'd0);

        // Randomized interleave against the reference model.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        mstep();
        m_drops   = 0;
        m_strobes = 0;
        dut_pops  = 0;
        check_model(-1);
        for (int c = 0; c < 1000; c++) begin
            drive(1'b0, ($urandom % 2) == 1, DW'($urandom), ($urandom % 10) < 3,
                  ($urandom % 16) == 0);
            mstep();
            check_model(c);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("rnd.accounting", 32'(dut_pops + int'(bus.count)), 32'(m_strobes - m_drops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_port_buffer.md
Name: out_port_buffer

Overview:
- Sits directly downstream of the processor's output port.
- Captures every OUT-instruction result (data plus a one-cycle strobe) into a small FIFO and presents it to an external peripheral over a valid/ready handshake.
- Decouples the non-stallable pipeline from a slow listener.
- Reports fill level, and keeps a sticky overflow flag for writes dropped while the FIFO is full.

Parameters:
- DATA_WIDTH, 16, width of outPortData and of each FIFO entry.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- PTR_W, log2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- outSignalEn  input  1  write strobe from the processor, high for one cycle per OUT instruction.
- outPortData  input  DATA_WIDTH  data from the processor, valid when outSignalEn=1.
- portReady  input  1  peripheral accepts the head entry this cycle.
- overflowClr  input  1  clears the sticky overflow flag.
- portValid  output  1  head entry available.
- portData  output  DATA_WIDTH  head entry; stable while portValid=1 and portReady=0.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=1 at a clk edge): wrPtr=0, rdPtr=0, count=0, overflow=0.
  - Consequently portValid=0, full=0 and portData=0.
  - Reset overrides all other inputs in the same cycle, including a strobe mid-stream.
  - Memory contents need not be cleared.
- Storage: DEPTH x DATA_WIDTH register array. Pointers wrap modulo DEPTH naturally (PTR_W bits). count is held explicitly.
- Outputs are decoded from registered state (no input-to-output combinational path):
  - portValid = (count != 0)
  - full = (count == DEPTH)
  - portData = mem[rdPtr] when portValid=1, else 0.
- Definitions:
  - push = outSignalEn && (!full || pop)
  - pop = portValid && portReady
  - drop = outSignalEn && full && !pop
- Push: mem[wrPtr] <= outPortData; wrPtr increments.
- Pop: rdPtr increments.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Latency: a strobe at edge N makes the data visible with portValid=1 after edge N (usable in cycle N+1). No same-cycle bypass, so empty+write+ready does not pop in that cycle.
- Full and simultaneous pop+write: both occur; the write is accepted; count stays DEPTH.
- Full and write without pop: data discarded; overflow <= 1; pointers and count unchanged.
- Empty and portReady=1: no effect.
- overflowClr=1: overflow <= 0, unless drop occurs in the same cycle, in which case set wins and overflow stays 1.
- Handshake: portData and portValid must not change while portValid=1 and portReady=0, except portData changing after a pop.
- Order: strictly FIFO; no reordering; no data duplication.

Decomposition:
- defines.v holds `outPortWidth (16) and `outBufDepth (8), beside the existing `inPortWidth. Top-level instantiation uses these.
- No shared typedefs needed; no FSM. State is limited to pointers, count and the flag.
- One natural sub-module, fifo_regarray: a synchronous write, asynchronous read register array (DEPTH x DATA_WIDTH; ports clk, we, waddr, wdata, raddr, rdata). It is reusable by a future input-port buffer.
- Full/empty/count logic stays in out_port_buffer.

Test Plan:
- Reset with an active strobe:
  - Stimulus: reset=1, outSignalEn=1, outPortData=16'hABCD for one cycle, then reset=0.
  - Required: count=0, portValid=0, overflow=0; no entry appears.
- Single write/read:
  - Stimulus: strobe 16'h1234 with portReady=0.
  - Required: next cycle portValid=1, portData=16'h1234, count=1. Holding portReady=0 for 5 cycles keeps data stable. portReady=1 for one cycle gives count=0, portValid=0.
- Fill and order:
  - Stimulus: 8 consecutive strobes with data 16'h0001..16'h0008, portReady=0.
  - Required: full=1, count=8.
  - Stimulus: then portReady=1 continuously.
  - Required: portData sequence 1..8 on consecutive cycles, then portValid=0; wrap verified.
- Overflow:
  - Stimulus: while full, strobe 16'hDEAD with portReady=0.
  - Required: overflow=1, count=8, and 16'hDEAD never emerges.
  - Stimulus: overflowClr=1 while a second drop occurs.
  - Required: overflow stays 1.
  - Stimulus: overflowClr alone.
  - Required: overflow=0.
- Full with simultaneous pop and push:
  - Stimulus: at count=8, head=16'h0001, strobe 16'h0009 with portReady=1.
  - Required: count stays 8, overflow=0, 16'h0009 emerges last.
- Random interleave:
  - Stimulus: 1000 cycles, strobe probability 0.5, portReady probability 0.3.
  - Required: a scoreboard model matches the output stream and drop count exactly; count always equals the model count.
